bf_match_reader: RTL and testbench

//  Downstream consumer of the bloom filter Avalon-ST source (candidate-match strings, one packet per string).

---
 rtl/bf_match_reader_pkg.sv | 37 +++
 rtl/bf_match_fifo.sv | 53 +++++
 rtl/bf_match_reader.sv | 172 +++++++++++++++++
 tb/tb_bf_match_reader.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_match_reader_pkg.sv
// Shared definitions for the bloom-filter match reader.
//   - CSR word addresses and STATUS / CTRL bit positions
//   - sink FSM state encoding
//   - entry_t: one buffered string {len, bytes} at the default geometry
//     (5-byte strings of 8-bit symbols); the top builds its own entry
//     type from its parameters so non-default geometries still work.
package bf_match_reader_pkg;

    localparam int CSR_STATUS   = 'h0;
    localparam int CSR_HEAD_LEN = 'h1;
    localparam int CSR_HEAD_B0  = 'h2;
    localparam int CSR_POP      = 'h8;
    localparam int CSR_DROP_CNT = 'h9;
    localparam int CSR_CTRL     = 'hA;

    localparam int ST_EMPTY = 9;
    localparam int ST_FULL  = 10;
    localparam int ST_OVF   = 11;
    localparam int ST_PERR  = 12;

    localparam int CTRL_DROP_MODE = 0;
    localparam int CTRL_CLEAR     = 1;

    localparam int DEF_MAX_STR_SIZE = 5;
    localparam int DEF_BYTE_W       = 8;

    typedef struct packed {
        logic [$clog2(DEF_MAX_STR_SIZE+1)-1:0]          len;
        logic [DEF_MAX_STR_SIZE-1:0][DEF_BYTE_W-1:0]    bytes;  // bytes[k] = k-th string byte
    } entry_t;

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_DISCARD = 1'b1
    } sink_state_e;

endpackage

// File: rtl/bf_match_fifo.sv
// Show-ahead synchronous FIFO.
//   clk, srst_n        clock, synchronous active-low reset
//   push, push_data    write request / data; push_ok = write actually taken
//   pop                read request; pop_ok = pop actually performed
//   rd_data            head entry (valid whenever !empty)
//   level, full, empty occupancy
// A push at full is still taken when a pop happens in the same cycle.
module bf_match_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         srst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    output logic                         push_ok,
    input  logic                         pop,
    output logic                         pop_ok,
    output logic [WIDTH-1:0]             rd_data,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         full,
    output logic                         empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;

    assign empty   = (level == '0);
    assign full    = (level == LVL_W'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push_ok) - LVL_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/bf_match_reader.sv
// Bloom-filter match reader: consumes single-word Avalon-ST string packets,
// buffers {len, bytes} in a FIFO and exposes them over an Avalon-MM CSR port.
//   main_clk_i / main_srst_n_i   clock, synchronous active-low reset
//   ast_sink_*                   Avalon-ST sink (one packet per string)
//   amm_slave_csr_*              CSR port, read latency 1
// CSR: 0x0 STATUS, 0x1 HEAD_LEN, 0x2.. HEAD bytes, 0x8 POP, 0x9 DROP_CNT, 0xA CTRL.
module bf_match_reader
    import bf_match_reader_pkg::*;
#(
    parameter int AST_SYMBOLS    = 8,
    parameter int AST_ORDER      = 1,
    parameter int AST_EMPTY_W    = (AST_SYMBOLS == 1) ? 1 : $clog2(AST_SYMBOLS),
    parameter int BYTE_W         = 8,
    parameter int MAX_STR_SIZE   = 5,
    parameter int FIFO_DEPTH     = 16,
    parameter int AMM_CSR_DATA_W = 16,
    parameter int AMM_CSR_ADDR_W = 4
) (
    input  logic                          main_clk_i,
    input  logic                          main_srst_n_i,
    input  logic                          ast_sink_valid_i,
    output logic                          ast_sink_ready_o,
    input  logic [AST_SYMBOLS*BYTE_W-1:0] ast_sink_data_i,
    input  logic [AST_EMPTY_W-1:0]        ast_sink_empty_i,
    input  logic                          ast_sink_startofpacket_i,
    input  logic                          ast_sink_endofpacket_i,
    input  logic [AMM_CSR_ADDR_W-1:0]     amm_slave_csr_address_i,
    input  logic                          amm_slave_csr_read_i,
    output logic [AMM_CSR_DATA_W-1:0]     amm_slave_csr_readdata_o,
    input  logic                          amm_slave_csr_write_i,
    input  logic [AMM_CSR_DATA_W-1:0]     amm_slave_csr_writedata_i
);
    localparam int LEN_W      = $clog2(MAX_STR_SIZE+1);
    localparam int LVL_W      = $clog2(FIFO_DEPTH+1);
    localparam int SYM_W      = $clog2(AST_SYMBOLS+1);
    localparam int HEAD_WORDS = (MAX_STR_SIZE + 1) / 2;

    typedef struct packed {
        logic [LEN_W-1:0]                     len;
        logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]  bytes;
    } str_entry_t;

    str_entry_t                              in_entry, head;
    logic [MAX_STR_SIZE-1:0][BYTE_W-1:0]     syms;
    logic [2*HEAD_WORDS-1:0][BYTE_W-1:0]     head_pad;
    logic [SYM_W-1:0]                        word_len;
    logic                                    len_ok, accept, push_req;
    logic                                    push_ok, pop_ok, fifo_full, fifo_empty;
    logic [LVL_W-1:0]                        fifo_level, level_nxt;
    logic                                    csr_pop, ctrl_wr, drop_mode_nxt;
    logic [AMM_CSR_DATA_W-1:0]               csr_rdata;

    sink_state_e                             state;
    logic                                    drop_mode, ovf, perr;
    logic [15:0]                             drop_cnt;

    // Byte k of the string is the k-th symbol in stream order.
    for (genvar k = 0; k < MAX_STR_SIZE; k++) begin : g_sym
        if (AST_ORDER == 1) begin : g_hi
            assign syms[k] = ast_sink_data_i[(AST_SYMBOLS-k)*BYTE_W-1 -: BYTE_W];
        end else begin : g_lo
            assign syms[k] = ast_sink_data_i[k*BYTE_W +: BYTE_W];
        end
    end

    assign word_len = SYM_W'(AST_SYMBOLS) - SYM_W'(ast_sink_empty_i);
    assign len_ok   = (word_len != '0) && (word_len <= SYM_W'(MAX_STR_SIZE));
    assign accept   = ast_sink_valid_i & ast_sink_ready_o;
    assign push_req = accept && (state == S_IDLE) && ast_sink_startofpacket_i
                      && ast_sink_endofpacket_i && len_ok;

    // Unused bytes are stored as zero so HEAD reads need no length masking.
    always_comb begin
        in_entry.len = LEN_W'(word_len);
        for (int k = 0; k < MAX_STR_SIZE; k++)
            in_entry.bytes[k] = (k < int'(word_len)) ? syms[k] : '0;
    end

    assign csr_pop       = amm_slave_csr_write_i && (int'(amm_slave_csr_address_i) == CSR_POP);
    assign ctrl_wr       = amm_slave_csr_write_i && (int'(amm_slave_csr_address_i) == CSR_CTRL);
    assign drop_mode_nxt = ctrl_wr ? amm_slave_csr_writedata_i[CTRL_DROP_MODE] : drop_mode;
    assign level_nxt     = fifo_level + LVL_W'(push_ok) - LVL_W'(pop_ok);

    bf_match_fifo #(
        .WIDTH ($bits(str_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (main_clk_i),
        .srst_n    (main_srst_n_i),
        .push      (push_req),
        .push_data (in_entry),
        .push_ok   (push_ok),
        .pop       (csr_pop),
        .pop_ok    (pop_ok),
        .rd_data   (head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // CSR read mux; reads see the head as it stands before a same-cycle pop.
    always_comb begin
        head_pad                   = '0;
        head_pad[MAX_STR_SIZE-1:0] = head.bytes;
        csr_rdata                  = '0;
        case (int'(amm_slave_csr_address_i))
            CSR_STATUS: begin
                csr_rdata[8:0]     = 9'(fifo_level);
                csr_rdata[ST_EMPTY] = fifo_empty;
                csr_rdata[ST_FULL]  = fifo_full;
                csr_rdata[ST_OVF]   = ovf;
                csr_rdata[ST_PERR]  = perr;
            end
            CSR_HEAD_LEN: if (!fifo_empty) csr_rdata = AMM_CSR_DATA_W'(head.len);
            CSR_DROP_CNT: csr_rdata = AMM_CSR_DATA_W'(drop_cnt);
            CSR_CTRL:     csr_rdata[CTRL_DROP_MODE] = drop_mode;
            default: begin
                for (int j = 0; j < HEAD_WORDS; j++)
                    if (int'(amm_slave_csr_address_i) == CSR_HEAD_B0 + j && !fifo_empty)
                        csr_rdata = AMM_CSR_DATA_W'({head_pad[2*j], head_pad[2*j+1]});
            end
        endcase
    end

    always_ff @(posedge main_clk_i) begin
        if (!main_srst_n_i) begin
            state                    <= S_IDLE;
            drop_mode                <= 1'b0;
            ovf                      <= 1'b0;
            perr                     <= 1'b0;
            drop_cnt                 <= '0;
            ast_sink_ready_o         <= 1'b0;
            amm_slave_csr_readdata_o <= '0;
        end else begin
            // Ready reflects occupancy after this edge so a pop reopens it next cycle.
            ast_sink_ready_o <= drop_mode_nxt | (level_nxt != LVL_W'(FIFO_DEPTH));
            amm_slave_csr_readdata_o <= amm_slave_csr_read_i ? csr_rdata : '0;

            if (accept) begin
                case (state)
                    S_IDLE: begin
                        if (!(ast_sink_startofpacket_i && ast_sink_endofpacket_i && len_ok))
                            perr <= 1'b1;
                        if (ast_sink_startofpacket_i && !ast_sink_endofpacket_i)
                            state <= S_DISCARD;
                    end
                    S_DISCARD: begin
                        if (ast_sink_startofpacket_i) perr  <= 1'b1;
                        if (ast_sink_endofpacket_i)   state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end

            if (push_req && !push_ok) begin
                ovf <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end

            // CLEAR is applied last so it beats a same-cycle drop or error.
            if (ctrl_wr) begin
                drop_mode <= amm_slave_csr_writedata_i[CTRL_DROP_MODE];
                if (amm_slave_csr_writedata_i[CTRL_CLEAR]) begin
                    ovf      <= 1'b0;
                    perr     <= 1'b0;
                    drop_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bf_match_reader.sv
module tb_bf_match_reader;
    import bf_match_reader_pkg::*;

    logic        clk = 1'b0;
    logic        srst_n = 1'b0;
    logic        valid = 1'b0, sop = 1'b0, eop = 1'b0;
    logic        ready;
    logic [63:0] data = '0;
    logic [2:0]  empty = '0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0, wr = 1'b0;
    logic [15:0] rdata, wdata = '0;

    always #5 clk = ~clk;

    bf_match_reader dut (
        .main_clk_i                (clk),
        .main_srst_n_i             (srst_n),
        .ast_sink_valid_i          (valid),
        .ast_sink_ready_o          (ready),
        .ast_sink_data_i           (data),
        .ast_sink_empty_i          (empty),
        .ast_sink_startofpacket_i  (sop),
        .ast_sink_endofpacket_i    (eop),
        .amm_slave_csr_address_i   (addr),
        .amm_slave_csr_read_i      (rd),
        .amm_slave_csr_readdata_o  (rdata),
        .amm_slave_csr_write_i     (wr),
        .amm_slave_csr_writedata_i (wdata)
    );

    int n_cmp = 0, n_err = 0;

    // Reference model: string queue plus sticky flags.
    entry_t q[$];
    bit     m_ovf, m_perr, m_mode, m_inpkt;
    int     m_cnt;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return m_mode || (q.size() < 16);
    endfunction

    function automatic logic [15:0] exp_reg(input int a);
        logic [7:0] b [6];
        for (int k = 0; k < 6; k++) b[k] = 8'h00;
        if (q.size() != 0) for (int k = 0; k < 5; k++) b[k] = q[0].bytes[k];
        case (a)
            0:       return {3'b000, m_perr, m_ovf, q.size() == 16, q.size() == 0, 9'(q.size())};
            1:       return (q.size() != 0) ? 16'(q[0].len) : 16'h0000;
            2, 3, 4: return {b[2*(a-2)], b[2*(a-2)+1]};
            9:       return 16'(m_cnt);
            10:      return {15'b0, m_mode};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void m_reset();
        q.delete();
        m_ovf = 0; m_perr = 0; m_mode = 0; m_inpkt = 0; m_cnt = 0;
    endfunction

    function automatic void m_word(input bit s, input bit e, input int emp, input logic [63:0] d);
        int len;
        entry_t ent;
        len = 8 - emp;
        if (!m_inpkt) begin
            if (s && e && len >= 1 && len <= 5) begin
                ent.len = 3'(len);
                for (int k = 0; k < 5; k++)
                    ent.bytes[k] = (k < len) ? 8'(d >> (8 * (7 - k))) : 8'h00;
                if (q.size() < 16) q.push_back(ent);
                else begin
                    m_ovf = 1;
                    if (m_cnt < 16'hFFFF) m_cnt++;
                end
            end else begin
                m_perr = 1;
                if (s && !e) m_inpkt = 1;
            end
        end else begin
            if (s) m_perr = 1;
            if (e) m_inpkt = 0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle with an optional stream word and an optional CSR write.
    task automatic cycle(input bit v, input bit s, input bit e, input int emp, input logic [63:0] d,
                         input bit w, input int a, input logic [15:0] wd);
        bit acc;
        if (v) check("ready", 16'(ready), 16'(m_ready()));
        acc   = v && m_ready();
        valid = v; sop = s; eop = e; empty = 3'(emp); data = d;
        wr = w; addr = 4'(a); wdata = wd;
        tick();
        valid = 0; sop = 0; eop = 0; wr = 0;
        if (w && a == 8 && q.size() != 0) void'(q.pop_front());
        if (acc) m_word(s, e, emp, d);
        if (w && a == 10) begin
            m_mode = wd[0];
            if (wd[1]) begin m_ovf = 0; m_perr = 0; m_cnt = 0; end
        end
    endtask

    task automatic send(input bit s, input bit e, input int emp, input logic [63:0] d);
        cycle(1'b1, s, e, emp, d, 1'b0, 0, 16'h0);
    endtask

    task automatic send_legal();
        send(1'b1, 1'b1, $urandom_range(3, 7), {$urandom, $urandom});
    endtask

    task automatic csr_write(input int a, input logic [15:0] wd);
        cycle(1'b0, 1'b0, 1'b0, 0, 64'h0, 1'b1, a, wd);
    endtask

    task automatic rd_check(input string tag, input int a);
        rd = 1; addr = 4'(a);
        tick();
        rd = 0;
        check(tag, rdata, exp_reg(a));
    endtask

    task automatic rd_const(input string tag, input int a, input logic [15:0] exp);
        rd = 1; addr = 4'(a);
        tick();
        rd = 0;
        check(tag, rdata, exp);
    endtask

    task automatic check_all(input string tag);
        for (int a = 0; a < 16; a++) rd_check($sformatf("%s_r%0d", tag, a), a);
    endtask

    task automatic drain();
        while (q.size() != 0) csr_write(8, 16'h0);
    endtask

    function automatic logic [63:0] mk_str(input string s);
        logic [63:0] d;
        d = 64'h0;
        for (int i = 0; i < s.len(); i++) d = d | (64'(s[i]) << (8 * (7 - i)));
        return d;
    endfunction

    initial begin
        m_reset();
        repeat (3) tick();
        check("rst_ready", 16'(ready), 16'h0);
        check("rst_rdata", rdata, 16'h0);
        srst_n = 1;
        repeat (2) tick();
        check_all("rst");

        // 1: single string "abc"
        send(1'b1, 1'b1, 5, mk_str("abc"));
        rd_const("t1_status", 0, 16'h0001);
        rd_const("t1_len", 1, 16'h0003);
        rd_const("t1_b0", 2, 16'h6162);
        rd_const("t1_b1", 3, 16'h6300);
        rd_const("t1_b2", 4, 16'h0000);
        csr_write(8, 16'h0);
        rd_const("t1_popped", 0, 16'h0200);

        // 2: back-pressure at full
        for (int i = 0; i < 16; i++) send_legal();
        rd_const("t2_full", 0, 16'h0410);
        check("t2_ready_lo", 16'(ready), 16'h0);
        csr_write(8, 16'h0);
        check("t2_ready_hi", 16'(ready), 16'h1);
        send_legal();
        check_all("t2");
        drain();

        // 3: drop mode overflow, CLEAR beats a same-cycle drop, pop+push at full
        csr_write(10, 16'h0001);
        for (int i = 0; i < 20; i++) send_legal();
        rd_const("t3_status", 0, 16'h0C10);
        rd_const("t3_dropcnt", 9, 16'h0004);
        cycle(1'b1, 1'b1, 1'b1, 4, {$urandom, $urandom}, 1'b1, 10, 16'h0003);
        rd_const("t3_clr_status", 0, 16'h0410);
        rd_const("t3_clr_cnt", 9, 16'h0000);
        cycle(1'b1, 1'b1, 1'b1, 5, {$urandom, $urandom}, 1'b1, 8, 16'h0);
        rd_const("t3_poppush", 0, 16'h0410);
        check_all("t3");
        drain();
        csr_write(10, 16'h0000);

        // 4: two-word packet is discarded, following string kept
        send(1'b1, 1'b0, 0, {$urandom, $urandom});
        send(1'b0, 1'b1, 3, {$urandom, $urandom});
        send(1'b1, 1'b1, 5, mk_str("xyz"));
        rd_const("t4_status", 0, 16'h1001);
        rd_const("t4_len", 1, 16'h0003);
        rd_const("t4_b0", 2, 16'h7879);
        rd_const("t4_b1", 3, 16'h7A00);
        csr_write(10, 16'h0002);
        drain();

        // 5: over-long string, pop on empty
        send(1'b1, 1'b1, 2, {$urandom, $urandom});
        rd_const("t5_status", 0, 16'h1200);
        csr_write(8, 16'h0);
        rd_const("t5_pop_empty", 0, 16'h1200);
        csr_write(10, 16'h0002);

        // Randomised traffic against the model
        for (int it = 0; it < 400; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 45) send_legal();
            else if (r < 55) send($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7), {$urandom, $urandom});
            else if (r < 72) csr_write(8, 16'($urandom));
            else if (r < 77) csr_write(10, 16'($urandom_range(0, 3)));
            else if (r < 87) rd_check("rnd_rd", $urandom_range(0, 15));
            else cycle(1'b1, 1'b1, 1'b1, $urandom_range(3, 7), {$urandom, $urandom}, 1'b1, 8, 16'h0);
            if (it % 50 == 49) check_all("rnd");
        end

        // 6: reset with entries and OVF pending
        csr_write(10, 16'h0003);
        drain();
        for (int i = 0; i < 17; i++) send_legal();
        for (int i = 0; i < 13; i++) csr_write(8, 16'h0);
        rd_const("t6_pre", 0, 16'h0803);
        srst_n = 0;
        tick();
        check("t6_ready_rst", 16'(ready), 16'h0);
        m_reset();
        srst_n = 1;
        rd_const("t6_status", 0, 16'h0200);
        check("t6_ready_up", 16'(ready), 16'h1);
        check_all("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
